// File: rtl/cont_bcd_pkg.sv
// Shared types and constants for the 4-digit BCD event counter.
package cont_bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX    = 4'd9;
    localparam int         NUM_DIGITS = 4;

    // Next value of a single BCD digit on increment; any code at or above 9 rolls to 0
    function automatic bcd_digit_t bcd_next(input bcd_digit_t d);
        return (d >= BCD_MAX) ? '0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/cont_bcd_digit.sv
// One decade of the BCD counter: a 0..9 digit with clear, increment and carry out.
module bcd_digit
    import cont_bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc_in,
    output bcd_digit_t digit,
    output logic       carry_out
);

    // Digit register: async reset, then clear beats increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (inc_in) begin
            digit <= bcd_next(digit);
        end
    end

    // Carry when this digit rolls over; an illegal code (>9) also rolls and carries
    assign carry_out = inc_in & (digit >= BCD_MAX);

endmodule

// File: rtl/cont_bcd.sv
// 4-digit decimal event counter (0000..9999) for the frequency-meter datapath.
// limp clears, hab opens the counting window; outputs come straight from the digit registers.
module cont_bcd
    import cont_bcd_pkg::*;
(
    input  logic       clk_amostra,
    input  logic       reset,
    input  logic       limp,
    input  logic       hab,
    output logic [3:0] cont_3,
    output logic [3:0] cont_2,
    output logic [3:0] cont_1,
    output logic [3:0] cont_0
);

    // inc[i] is the increment request into digit i; inc[NUM_DIGITS] is the full-scale rollover
    logic [NUM_DIGITS:0] inc;
    bcd_digit_t          digits [NUM_DIGITS];
    logic                top_carry_unused;

    assign inc[0] = hab;

    genvar i;
    generate
        for (i = 0; i < NUM_DIGITS; i++) begin : g_digit
            bcd_digit u_digit (
                .clk       (clk_amostra),
                .rst       (reset),
                .clr       (limp),
                .inc_in    (inc[i]),
                .digit     (digits[i]),
                .carry_out (inc[i+1])
            );
        end
    endgenerate

    // 9999 -> 0000 simply wraps; the final carry has no consumer
    assign top_carry_unused = inc[NUM_DIGITS];

    assign cont_0 = digits[0];
    assign cont_1 = digits[1];
    assign cont_2 = digits[2];
    assign cont_3 = digits[3];

endmodule

// File: tb/tb_cont_bcd.sv
// Self-checking bench for cont_bcd against an integer event-count model.
module tb_cont_bcd;

    logic       clk_amostra;
    logic       reset;
    logic       limp;
    logic       hab;
    logic [3:0] cont_3;
    logic [3:0] cont_2;
    logic [3:0] cont_1;
    logic [3:0] cont_0;

    int errors = 0;
    int checks = 0;
    int model_n = 0;   // enabled edges since last clear, mod 10000

    cont_bcd dut (
        .clk_amostra (clk_amostra),
        .reset       (reset),
        .limp        (limp),
        .hab         (hab),
        .cont_3      (cont_3),
        .cont_2      (cont_2),
        .cont_1      (cont_1),
        .cont_0      (cont_0)
    );

    initial clk_amostra = 1'b0;
    always #5 clk_amostra = ~clk_amostra;

    // Decimal reading of the DUT outputs (4'hx-free assumed; digit legality checked separately)
    function automatic int dut_value();
        return int'(cont_3) * 1000 + int'(cont_2) * 100 + int'(cont_1) * 10 + int'(cont_0);
    endfunction

    // One rising edge; the model applies the inputs that were present at that edge
    task automatic tick();
        logic r, l, h;
        r = reset; l = limp; h = hab;
        @(posedge clk_amostra);
        #1;
        if (r || l) model_n = 0;
        else if (h) model_n = (model_n + 1) % 10000;
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; limp = 1'b0; hab = 1'b0;
        model_n = 0;
        #2;
        checks++;
        if ({cont_3, cont_2, cont_1, cont_0} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_initial: got %h%h%h%h expected 0000", cont_3, cont_2, cont_1, cont_0);
        end
        tick();
        reset = 1'b0;
        limp = 1'b1; tick(); limp = 1'b0;
        hab = 1'b1; tick_n(357);
        checks++;
        if ({cont_3, cont_2, cont_1, cont_0} !== 16'h0357) begin
            errors++;
            $display("FAIL reset_precount: got %h%h%h%h expected 0357", cont_3, cont_2, cont_1, cont_0);
        end
        // assert reset between edges, no clock edge needed
        #2;
        reset = 1'b1;
        #1;
        model_n = 0;
        checks++;
        if ({cont_3, cont_2, cont_1, cont_0} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_async: got %h%h%h%h expected 0000", cont_3, cont_2, cont_1, cont_0);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({cont_3, cont_2, cont_1, cont_0} !== 16'h0000) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %h%h%h%h expected 0000", k, cont_3, cont_2, cont_1, cont_0);
            end
        end
        hab = 1'b0;
        #2;
        reset = 1'b0;
    endtask

    task automatic test_basic_count();
        int held;
        limp = 1'b1; hab = 1'b0; tick(); limp = 1'b0;
        hab = 1'b1; tick_n(37); hab = 1'b0;
        checks++;
        if (cont_3 !== 4'(model_n / 1000) || cont_2 !== 4'((model_n / 100) % 10) ||
            cont_1 !== 4'((model_n / 10) % 10) || cont_0 !== 4'(model_n % 10) || model_n != 37) begin
            errors++;
            $display("FAIL basic_37: got %h%h%h%h expected 0037", cont_3, cont_2, cont_1, cont_0);
        end
        tick_n(10);
        held = dut_value();
        checks++;
        if (held != 37 || model_n != 37) begin
            errors++;
            $display("FAIL basic_hold: got %0d expected 37", held);
        end
    endtask

    task automatic test_carry_chain();
        int v;
        limp = 1'b1; hab = 1'b0; tick(); limp = 1'b0;
        hab = 1'b1;
        tick_n(100);
        v = dut_value();
        checks++;
        if (v != model_n) begin
            errors++;
            $display("FAIL carry_100: got %0d expected %0d", v, model_n);
        end
        tick_n(899);
        v = dut_value();
        checks++;
        if (v != model_n || {cont_3, cont_2, cont_1, cont_0} !== 16'h0999) begin
            errors++;
            $display("FAIL carry_999: got %h%h%h%h expected 0999", cont_3, cont_2, cont_1, cont_0);
        end
        tick();
        checks++;
        if ({cont_3, cont_2, cont_1, cont_0} !== 16'h1000) begin
            errors++;
            $display("FAIL carry_1000: got %h%h%h%h expected 1000", cont_3, cont_2, cont_1, cont_0);
        end
        hab = 1'b0;
    endtask

    task automatic test_wrap();
        limp = 1'b1; hab = 1'b0; tick(); limp = 1'b0;
        hab = 1'b1;
        tick_n(9999);
        checks++;
        if ({cont_3, cont_2, cont_1, cont_0} !== 16'h9999) begin
            errors++;
            $display("FAIL wrap_9999: got %h%h%h%h expected 9999", cont_3, cont_2, cont_1, cont_0);
        end
        tick();
        checks++;
        if ({cont_3, cont_2, cont_1, cont_0} !== 16'h0000 || model_n != 0) begin
            errors++;
            $display("FAIL wrap_0000: got %h%h%h%h expected 0000", cont_3, cont_2, cont_1, cont_0);
        end
        hab = 1'b0;
    endtask

    task automatic test_clear_priority();
        limp = 1'b1; hab = 1'b0; tick(); limp = 1'b0;
        hab = 1'b1; tick_n(42);
        checks++;
        if ({cont_3, cont_2, cont_1, cont_0} !== 16'h0042) begin
            errors++;
            $display("FAIL clrpri_42: got %h%h%h%h expected 0042", cont_3, cont_2, cont_1, cont_0);
        end
        limp = 1'b1; hab = 1'b1; tick();
        checks++;
        if ({cont_3, cont_2, cont_1, cont_0} !== 16'h0000) begin
            errors++;
            $display("FAIL clrpri_both: got %h%h%h%h expected 0000", cont_3, cont_2, cont_1, cont_0);
        end
        limp = 1'b0; hab = 1'b0; tick();
        checks++;
        if ({cont_3, cont_2, cont_1, cont_0} !== 16'h0000) begin
            errors++;
            $display("FAIL clrpri_after: got %h%h%h%h expected 0000", cont_3, cont_2, cont_1, cont_0);
        end
    endtask

    task automatic test_random_windows();
        int edges_on;
        int len;
        int v;
        logic digits_ok;
        for (int w = 0; w < 12; w++) begin
            limp = 1'b1; hab = 1'b0; tick(); limp = 1'b0;
            edges_on = 0;
            digits_ok = 1'b1;
            len = $urandom_range(400, 5);
            for (int k = 0; k < len; k++) begin
                hab = ($urandom_range(3, 0) != 0);
                if (hab) edges_on++;
                tick();
                if (cont_3 > 4'd9 || cont_2 > 4'd9 || cont_1 > 4'd9 || cont_0 > 4'd9) digits_ok = 1'b0;
            end
            hab = 1'b0;
            tick_n($urandom_range(4, 0));
            v = dut_value();
            checks++;
            if (v != edges_on || v != model_n) begin
                errors++;
                $display("FAIL rand_window[%0d]: got %0d expected %0d", w, v, edges_on);
            end
            checks++;
            if (!digits_ok) begin
                errors++;
                $display("FAIL rand_digit_range[%0d]: got a digit above 9 expected all digits <= 9", w);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_count();
        test_carry_chain();
        test_wrap();
        test_clear_priority();
        test_random_windows();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
